uart_tx_scheduler: RTL and testbench

//  Transmit-side controller for the UART baud-rate generator. Owns that generator's

---
 rtl/uart_tx_scheduler_if.sv | 24 ++
 rtl/uart_tx_scheduler.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_if.sv
// Byte handshake between the command/status byte source and the UART TX scheduler.
// The source drives tx_data/tx_valid; the scheduler answers with tx_ready/tx_busy.
interface uart_tx_scheduler_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_busy;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_busy
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_busy
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// UART transmit scheduler: owns the baud generator's rate select and serialises one
// frame (start, data LSB-first, optional parity, stop) per accepted byte, stepping only
// on the generator's uart_enable tick. Rate changes requested mid-frame are deferred
// until the frame ends.
// Optional feature: define UART_TX_SCHEDULER_PARITY_EN to insert an even-parity bit.
module uart_tx_scheduler #(
  parameter int unsigned DATA_BITS        = 8,
  parameter int unsigned STOP_BITS        = 1,
  parameter logic [2:0]  DEFAULT_BAUD_SEL = 3'd1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [2:0]         cfg_baud_sel,
  input  logic               cfg_baud_wr,
  output logic [2:0]         baudrate_sel,
  input  logic               uart_enable,
  output logic               tx_serial,
  uart_tx_scheduler_if.slave tx_if
);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  localparam logic [2:0] LastBit  = 3'(DATA_BITS - 1);
  localparam logic       LastStop = 1'(STOP_BITS - 1);

  state_e               state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [2:0]           bit_cnt_q;
  logic                 stop_cnt_q;
  logic [2:0]           baud_q;
  logic [2:0]           pend_sel_q;
  logic                 pend_q;
  logic                 serial_q;
  logic                 ready_q;
  logic                 busy_q;
`ifdef UART_TX_SCHEDULER_PARITY_EN
  logic                 parity_q;
`endif

  logic [2:0] pend_next_sel;
  logic       pend_next;

  // A write landing on the final stop tick is newer than anything already pending.
  always_comb begin
    pend_next     = pend_q | cfg_baud_wr;
    pend_next_sel = cfg_baud_wr ? cfg_baud_sel : pend_sel_q;
  end

  // Frame sequencer with registered line, handshake and rate-select outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      baud_q     <= DEFAULT_BAUD_SEL;
      pend_sel_q <= '0;
      pend_q     <= 1'b0;
      serial_q   <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_SCHEDULER_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      // Capture first so the frame-end branch below can clear it.
      if (state_q != StIdle && cfg_baud_wr) begin
        pend_q     <= 1'b1;
        pend_sel_q <= cfg_baud_sel;
      end

      unique case (state_q)
        StIdle: begin
          if (cfg_baud_wr) begin
            baud_q <= cfg_baud_sel;
          end
          if (tx_if.tx_valid && ready_q) begin
            shift_q <= tx_if.tx_data;
`ifdef UART_TX_SCHEDULER_PARITY_EN
            parity_q <= ^tx_if.tx_data;
`endif
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StArm;
          end else begin
            // Also re-opens the handshake one clock after a deferred rate is applied.
            ready_q <= 1'b1;
          end
        end

        // Waiting here puts the start bit on the tick grid.
        StArm: begin
          if (uart_enable) begin
            serial_q <= 1'b0;
            state_q  <= StStart;
          end
        end

        StStart: begin
          if (uart_enable) begin
            serial_q  <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= '0;
            state_q   <= StData;
          end
        end

        StData: begin
          if (uart_enable) begin
            if (bit_cnt_q == LastBit) begin
`ifdef UART_TX_SCHEDULER_PARITY_EN
              serial_q <= parity_q;
              state_q  <= StParity;
`else
              serial_q   <= 1'b1;
              stop_cnt_q <= 1'b0;
              state_q    <= StStop;
`endif
            end else begin
              serial_q  <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end

        StParity: begin
          if (uart_enable) begin
            serial_q   <= 1'b1;
            stop_cnt_q <= 1'b0;
            state_q    <= StStop;
          end
        end

        StStop: begin
          if (uart_enable) begin
            if (stop_cnt_q == LastStop) begin
              serial_q <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= StIdle;
              if (pend_next) begin
                baud_q  <= pend_next_sel;
                pend_q  <= 1'b0;
                ready_q <= 1'b0;
              end else begin
                ready_q <= 1'b1;
              end
            end else begin
              stop_cnt_q <= stop_cnt_q + 1'b1;
            end
          end
        end

        default: begin
          serial_q <= 1'b1;
          busy_q   <= 1'b0;
          ready_q  <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  assign baudrate_sel   = baud_q;
  assign tx_serial      = serial_q;
  assign tx_if.tx_ready = ready_q;
  assign tx_if.tx_busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: frame table checked bit-by-bit, plus
// hand-written back-to-back, deferred-config, idle-config and async-reset sequences.
module tb_uart_tx_scheduler;

  logic       clock;
  logic       reset_n;
  logic [2:0] cfg_baud_sel;
  logic       cfg_baud_wr;
  logic [2:0] baudrate_sel;
  logic       uart_enable;
  logic       tx_serial;

  uart_tx_scheduler_if #(.DATA_BITS(8)) bus ();

  uart_tx_scheduler dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .cfg_baud_sel (cfg_baud_sel),
    .cfg_baud_wr  (cfg_baud_wr),
    .baudrate_sel (baudrate_sel),
    .uart_enable  (uart_enable),
    .tx_serial    (tx_serial),
    .tx_if        (bus)
  );

`ifdef UART_TX_SCHEDULER_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif

  // line holds the frame MSB-first: bit FrameBits-1 is the start bit.
  typedef struct {
    logic [7:0]  data;
    logic [10:0] line;
  } vec_t;

  vec_t       vecs [7];
  int         checks   = 0;
  int         failures = 0;
  logic [2:0] exp_baud;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // One-clock uart_enable pulse every 4 clocks, changed on the falling edge.
  initial begin
    int ph;
    ph = 0;
    uart_enable = 1'b0;
    forever begin
      @(negedge clock);
      uart_enable = (ph == 0);
      ph = (ph == 3) ? 0 : ph + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_tick(output int waited);
    waited = 0;
    do begin
      @(posedge clock);
      waited++;
    end while (!uart_enable && waited < 16);
    check("tick_seen", 32'(uart_enable), 32'd1);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.tx_ready && n < 64) begin
      @(negedge clock);
      n++;
    end
    check("ready_before_send", 32'(bus.tx_ready), 32'd1);
  endtask

  // One bit period starting at the falling edge after a tick; optional cfg pulse.
  task automatic expect_bit(input logic exp, input bit cfg_en, input logic [2:0] cfg_val);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      check("line_bit", 32'(tx_serial), 32'(exp));
      check("busy_in_frame", 32'(bus.tx_busy), 32'd1);
      check("baud_hold", 32'(baudrate_sel), 32'(exp_baud));
      if (c == 0 && cfg_en) begin
        check("ready_low_on_cfg", 32'(bus.tx_ready), 32'd0);
        cfg_baud_wr  = 1'b1;
        cfg_baud_sel = cfg_val;
      end
      if (c == 1 && cfg_en) cfg_baud_wr = 1'b0;
    end
  endtask

  task automatic expect_frame(input int idx, input int at1, input logic [2:0] v1,
                              input int at2, input logic [2:0] v2);
    for (int b = 0; b < FrameBits; b++) begin
      expect_bit(vecs[idx].line[FrameBits-1-b], (b == at1) || (b == at2),
                 (b == at1) ? v1 : v2);
    end
  endtask

  task automatic send_byte(input int idx);
    int w;
    wait_ready();
    bus.tx_valid = 1'b1;
    bus.tx_data  = vecs[idx].data;
    @(negedge clock);
    check("accept_busy", 32'(bus.tx_busy), 32'd1);
    check("accept_ready", 32'(bus.tx_ready), 32'd0);
    bus.tx_valid = 1'b0;
    wait_tick(w);
  endtask

  task automatic expect_frame_end(input logic exp_ready);
    @(negedge clock);
    check("end_busy", 32'(bus.tx_busy), 32'd0);
    check("end_ready", 32'(bus.tx_ready), 32'(exp_ready));
    check("end_line", 32'(tx_serial), 32'd1);
  endtask

  initial begin
    int w;
`ifdef UART_TX_SCHEDULER_PARITY_EN
    vecs[0] = '{8'hA5, 11'b01010010101};
    vecs[1] = '{8'h07, 11'b01110000011};
    vecs[2] = '{8'h00, 11'b00000000001};
    vecs[3] = '{8'hFF, 11'b01111111101};
    vecs[4] = '{8'h3C, 11'b00011110001};
    vecs[5] = '{8'h55, 11'b01010101001};
    vecs[6] = '{8'h0F, 11'b01111000001};
`else
    vecs[0] = '{8'hA5, 11'b0_0101001011};
    vecs[1] = '{8'h07, 11'b0_0111000001};
    vecs[2] = '{8'h00, 11'b0_0000000001};
    vecs[3] = '{8'hFF, 11'b0_0111111111};
    vecs[4] = '{8'h3C, 11'b0_0001111001};
    vecs[5] = '{8'h55, 11'b0_0101010101};
    vecs[6] = '{8'h0F, 11'b0_0111100001};
`endif

    reset_n      = 1'b0;
    cfg_baud_sel = 3'd0;
    cfg_baud_wr  = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    exp_baud     = 3'd1;

    // Reset values.
    repeat (3) @(negedge clock);
    check("rst_baud", 32'(baudrate_sel), 32'd1);
    check("rst_line", 32'(tx_serial), 32'd1);
    check("rst_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_busy", 32'(bus.tx_busy), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Single frames from the table.
    for (int i = 0; i < 5; i++) begin
      send_byte(i);
      expect_frame(i, -1, 3'd0, -1, 3'd0);
      expect_frame_end(1'b1);
    end

    // Back-to-back: valid held, second byte accepted in the first idle cycle.
    wait_ready();
    bus.tx_valid = 1'b1;
    bus.tx_data  = vecs[5].data;
    @(negedge clock);
    check("b2b_accept1", 32'(bus.tx_busy), 32'd1);
    bus.tx_data = vecs[6].data;
    wait_tick(w);
    expect_frame(5, -1, 3'd0, -1, 3'd0);
    expect_frame_end(1'b1);
    @(negedge clock);
    check("b2b_accept2_busy", 32'(bus.tx_busy), 32'd1);
    check("b2b_accept2_ready", 32'(bus.tx_ready), 32'd0);
    bus.tx_valid = 1'b0;
    wait_tick(w);
    check("b2b_start_on_next_tick", 32'(w), 32'd3);
    expect_frame(6, -1, 3'd0, -1, 3'd0);
    expect_frame_end(1'b1);

    // Mid-frame config: two writes, last one applied on entering idle.
    send_byte(0);
    expect_frame(0, 2, 3'd6, 5, 3'd4);
    expect_frame_end(1'b0);
    check("cfg_applied_at_idle", 32'(baudrate_sel), 32'd4);
    exp_baud = 3'd4;
    @(negedge clock);
    check("ready_after_apply", 32'(bus.tx_ready), 32'd1);

    // Idle config with a byte in the same cycle.
    @(negedge clock);
    cfg_baud_wr  = 1'b1;
    cfg_baud_sel = 3'd2;
    bus.tx_valid = 1'b1;
    bus.tx_data  = vecs[2].data;
    @(negedge clock);
    cfg_baud_wr  = 1'b0;
    bus.tx_valid = 1'b0;
    check("idle_cfg_baud", 32'(baudrate_sel), 32'd2);
    check("idle_cfg_accept", 32'(bus.tx_busy), 32'd1);
    exp_baud = 3'd2;
    wait_tick(w);
    expect_frame(2, -1, 3'd0, -1, 3'd0);
    expect_frame_end(1'b1);

    // Async reset during data bit 3 of 8'hA5 (line low there).
    send_byte(0);
    for (int b = 0; b < 4; b++) expect_bit(vecs[0].line[FrameBits-1-b], 1'b0, 3'd0);
    @(negedge clock);
    check("pre_reset_bit3", 32'(tx_serial), 32'd0);
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_line", 32'(tx_serial), 32'd1);
    check("async_rst_busy", 32'(bus.tx_busy), 32'd0);
    check("async_rst_ready", 32'(bus.tx_ready), 32'd1);
    check("async_rst_baud", 32'(baudrate_sel), 32'd1);
    @(negedge clock);
    reset_n  = 1'b1;
    exp_baud = 3'd1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      check("post_rst_line", 32'(tx_serial), 32'd1);
      check("post_rst_busy", 32'(bus.tx_busy), 32'd0);
    end

    // Normal operation after reset.
    send_byte(3);
    expect_frame(3, -1, 3'd0, -1, 3'd0);
    expect_frame_end(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
